// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM timer core: bit positions inside a channel cfg word.
package pwm_pkg;

  localparam int CFG_EN   = 0;
  localparam int CFG_POL  = 1;
  localparam int CFG_CEN  = 2;
  localparam int CFG_CPOL = 3;

endpackage

// File: rtl/pwm_deadtime.sv
// Dead-time generator for one complementary pair: splits a registered reference into
// non-overlapping main/comp active levels, each edge delayed on its asserting side by dtg_i cycles.
module pwm_deadtime #(
  parameter int DTG_W = 8
) (
  input  logic             clk_psc_i,
  input  logic             rst_n_i,
  input  logic             ref_i,
  input  logic [DTG_W-1:0] dtg_i,
  input  logic             en_i,
  output logic             main_o,
  output logic             comp_o
);

  logic             ref_d;
  logic [DTG_W-1:0] age_q;
  logic [DTG_W-1:0] age;
  logic             settled;

  // age counts cycles the reference has held its current level; a level that
  // does not survive dtg_i cycles never reaches its output.
  always_comb begin
    age     = (ref_i != ref_d) ? '0 : age_q;
    settled = (age >= dtg_i);
    main_o  = en_i &  ref_i & settled;
    comp_o  = en_i & ~ref_i & settled;
  end

  always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ref_d <= 1'b0;
      age_q <= '0;
    end else begin
      ref_d <= ref_i;
      if (!en_i) begin
        age_q <= '0;
      end else if (&age) begin
        age_q <= age;
      end else begin
        age_q <= age + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pwm_timer_core.sv
// One PWM timer: prescaler, auto-reload up-counter, shadowed configuration and two
// compare channels, each driving a dead-time complementary output pair.
module pwm_timer_core
  import pwm_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DTG_W = 8
) (
  input  logic             clk_psc_i,
  input  logic             rst_n_i,
  input  logic             cen_i,
  input  logic [WIDTH-1:0] psc_preload_i,
  input  logic [WIDTH-1:0] arr_preload_i,
  input  logic [WIDTH-1:0] cmp_a_start_i,
  input  logic [WIDTH-1:0] cmp_a_end_i,
  input  logic [WIDTH-1:0] cfg_a_i,
  input  logic [DTG_W-1:0] dtg_a_i,
  input  logic [WIDTH-1:0] cmp_b_start_i,
  input  logic [WIDTH-1:0] cmp_b_end_i,
  input  logic [WIDTH-1:0] cfg_b_i,
  input  logic [DTG_W-1:0] dtg_b_i,
  output logic             pwm_a_o,
  output logic             pwm_an_o,
  output logic             pwm_b_o,
  output logic             pwm_bn_o,
  output logic [WIDTH-1:0] cnt_o,
  output logic             uev_o
);

  logic             cen_q;
  logic [WIDTH-1:0] psc_cnt;
  logic [WIDTH-1:0] psc_sh, arr_sh;
  logic [WIDTH-1:0] a_start_sh, a_end_sh, cfg_a_sh;
  logic [WIDTH-1:0] b_start_sh, b_end_sh, cfg_b_sh;
  logic [DTG_W-1:0] dtg_a_sh, dtg_b_sh;
  logic             ref_a_q, ref_b_q;
  logic             main_a, comp_a, main_b, comp_b;
  logic             load, run, tick, wrap;

  function automatic logic ref_level(input logic [WIDTH-1:0] c,
                                     input logic [WIDTH-1:0] s,
                                     input logic [WIDTH-1:0] e);
    if (s < e)      return (c >= s) && (c < e);
    else if (s > e) return (c >= s) || (c < e);
    else            return 1'b0;
  endfunction

  // run only once the forced shadow load has happened, so the first counting
  // cycle and the channels always see the freshly loaded configuration.
  always_comb begin
    load = cen_i & ~cen_q;
    run  = cen_i &  cen_q;
    tick = run && (psc_cnt == psc_sh);
    wrap = tick && (cnt_o == arr_sh);
  end

  always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cen_q   <= 1'b0;
      psc_cnt <= '0;
      cnt_o   <= '0;
      uev_o   <= 1'b0;
    end else begin
      cen_q <= cen_i;
      uev_o <= wrap;
      if (!run) begin
        psc_cnt <= '0;
        cnt_o   <= '0;
      end else if (tick) begin
        psc_cnt <= '0;
        cnt_o   <= wrap ? '0 : cnt_o + 1'b1;
      end else begin
        psc_cnt <= psc_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      psc_sh     <= '0;
      arr_sh     <= '1;
      a_start_sh <= '0;
      a_end_sh   <= '0;
      cfg_a_sh   <= '0;
      dtg_a_sh   <= '0;
      b_start_sh <= '0;
      b_end_sh   <= '0;
      cfg_b_sh   <= '0;
      dtg_b_sh   <= '0;
    end else if (load || wrap) begin
      psc_sh     <= psc_preload_i;
      arr_sh     <= arr_preload_i;
      a_start_sh <= cmp_a_start_i;
      a_end_sh   <= cmp_a_end_i;
      cfg_a_sh   <= cfg_a_i;
      dtg_a_sh   <= dtg_a_i;
      b_start_sh <= cmp_b_start_i;
      b_end_sh   <= cmp_b_end_i;
      cfg_b_sh   <= cfg_b_i;
      dtg_b_sh   <= dtg_b_i;
    end
  end

  always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ref_a_q <= 1'b0;
      ref_b_q <= 1'b0;
    end else begin
      ref_a_q <= run && ref_level(cnt_o, a_start_sh, a_end_sh);
      ref_b_q <= run && ref_level(cnt_o, b_start_sh, b_end_sh);
    end
  end

  pwm_deadtime #(.DTG_W(DTG_W)) u_dt_a (
    .clk_psc_i (clk_psc_i),
    .rst_n_i   (rst_n_i),
    .ref_i     (ref_a_q),
    .dtg_i     (dtg_a_sh),
    .en_i      (run & cfg_a_sh[CFG_EN]),
    .main_o    (main_a),
    .comp_o    (comp_a)
  );

  pwm_deadtime #(.DTG_W(DTG_W)) u_dt_b (
    .clk_psc_i (clk_psc_i),
    .rst_n_i   (rst_n_i),
    .ref_i     (ref_b_q),
    .dtg_i     (dtg_b_sh),
    .en_i      (run & cfg_b_sh[CFG_EN]),
    .main_o    (main_b),
    .comp_o    (comp_b)
  );

  always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pwm_a_o  <= 1'b0;
      pwm_an_o <= 1'b0;
      pwm_b_o  <= 1'b0;
      pwm_bn_o <= 1'b0;
    end else begin
      pwm_a_o  <= main_a ^ cfg_a_sh[CFG_POL];
      pwm_an_o <= (comp_a & cfg_a_sh[CFG_CEN]) ^ cfg_a_sh[CFG_CPOL];
      pwm_b_o  <= main_b ^ cfg_b_sh[CFG_POL];
      pwm_bn_o <= (comp_b & cfg_b_sh[CFG_CEN]) ^ cfg_b_sh[CFG_CPOL];
    end
  end

endmodule

// File: tb/tb_pwm_timer_core.sv
// Directed bench for pwm_timer_core: per-cycle expected output vectors are queued by the
// stimulus and popped/compared by a negedge monitor.
module tb_pwm_timer_core;

  localparam int WIDTH = 16;
  localparam int DTG_W = 8;
  localparam int VW    = WIDTH + 5;
  localparam logic [VW-1:0] FULL = {VW{1'b1}};

  logic             clk_psc_i;
  logic             rst_n_i;
  logic             cen_i;
  logic [WIDTH-1:0] psc_preload_i, arr_preload_i;
  logic [WIDTH-1:0] cmp_a_start_i, cmp_a_end_i, cfg_a_i;
  logic [WIDTH-1:0] cmp_b_start_i, cmp_b_end_i, cfg_b_i;
  logic [DTG_W-1:0] dtg_a_i, dtg_b_i;
  logic             pwm_a_o, pwm_an_o, pwm_b_o, pwm_bn_o;
  logic [WIDTH-1:0] cnt_o;
  logic             uev_o;

  pwm_timer_core #(.WIDTH(WIDTH), .DTG_W(DTG_W)) dut (
    .clk_psc_i     (clk_psc_i),
    .rst_n_i       (rst_n_i),
    .cen_i         (cen_i),
    .psc_preload_i (psc_preload_i),
    .arr_preload_i (arr_preload_i),
    .cmp_a_start_i (cmp_a_start_i),
    .cmp_a_end_i   (cmp_a_end_i),
    .cfg_a_i       (cfg_a_i),
    .dtg_a_i       (dtg_a_i),
    .cmp_b_start_i (cmp_b_start_i),
    .cmp_b_end_i   (cmp_b_end_i),
    .cfg_b_i       (cfg_b_i),
    .dtg_b_i       (dtg_b_i),
    .pwm_a_o       (pwm_a_o),
    .pwm_an_o      (pwm_an_o),
    .pwm_b_o       (pwm_b_o),
    .pwm_bn_o      (pwm_bn_o),
    .cnt_o         (cnt_o),
    .uev_o         (uev_o)
  );

  // clock / reset
  initial clk_psc_i = 1'b0;
  always #5 clk_psc_i = ~clk_psc_i;

  // scoreboard
  logic [VW-1:0] exp_q[$];
  logic [VW-1:0] msk_q[$];
  int            tag_q[$];
  int            n_vec  = 0;
  int            n_miss = 0;
  logic [VW-1:0] m_exp, m_msk, m_act;
  int            m_tag;

  always @(negedge clk_psc_i) begin
    if (exp_q.size() > 0) begin
      m_exp = exp_q.pop_front();
      m_msk = msk_q.pop_front();
      m_tag = tag_q.pop_front();
      m_act = {pwm_a_o, pwm_an_o, pwm_b_o, pwm_bn_o, uev_o, cnt_o};
      if (m_msk != '0) begin
        n_vec++;
        if (((m_act ^ m_exp) & m_msk) != '0) begin
          n_miss++;
          $display("FAIL test%0d @%0t: got a/an/b/bn/uev=%b cnt=%0d, want %b cnt=%0d",
                   m_tag, $time, m_act[VW-1:WIDTH], m_act[WIDTH-1:0],
                   m_exp[VW-1:WIDTH], m_exp[WIDTH-1:0]);
        end
      end
    end
  end

  function automatic logic [VW-1:0] vec(input logic a, input logic an, input logic b,
                                        input logic bn, input logic u,
                                        input logic [WIDTH-1:0] c);
    return {a, an, b, bn, u, c};
  endfunction

  // k = index of the active edge after a forced load (edge 0 is the load edge)
  function automatic logic [WIDTH-1:0] cnt10(input int k);
    return (k < 0) ? '0 : WIDTH'(k % 10);
  endfunction

  function automatic logic uev10(input int k);
    return (k > 0) && (k % 10 == 0);
  endfunction

  // dtg=2, 3-cycle reference at cycles j%10 in 3..5
  function automatic logic t2_main(input int j);
    return (j >= 0) && (j % 10 == 5);
  endfunction

  function automatic logic t2_comp(input int j);
    return (j >= 2) && ((j % 10 >= 8) || (j % 10 <= 2));
  endfunction

  // dtg=5: the 3-cycle pulse never survives; comp settles 5 cycles after each fall
  function automatic logic t5_comp(input int j);
    return (j >= 11) && ((j % 10 == 1) || (j % 10 == 2));
  endfunction

  // driver tasks
  task automatic push(input logic [VW-1:0] v, input logic [VW-1:0] m, input int tag);
    exp_q.push_back(v);
    msk_q.push_back(m);
    tag_q.push_back(tag);
  endtask

  task automatic advance(input int n);
    repeat (n) @(posedge clk_psc_i);
    #1;
  endtask

  task automatic set_ch_a(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] e,
                          input logic [WIDTH-1:0] cfg, input logic [DTG_W-1:0] dtg);
    cmp_a_start_i = s; cmp_a_end_i = e; cfg_a_i = cfg; dtg_a_i = dtg;
  endtask

  task automatic set_ch_b(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] e,
                          input logic [WIDTH-1:0] cfg, input logic [DTG_W-1:0] dtg);
    cmp_b_start_i = s; cmp_b_end_i = e; cfg_b_i = cfg; dtg_b_i = dtg;
  endtask

  // drop cen: the first edge without cen must already show cnt 0, no uev, idle pins
  task automatic stop_timer(input logic ia, input logic ian, input logic ib, input logic ibn,
                            input int tag);
    cen_i = 1'b0;
    push('0, '0, tag);
    push(vec(ia, ian, ib, ibn, 1'b0, '0), FULL, tag);
    push(vec(ia, ian, ib, ibn, 1'b0, '0), FULL, tag);
    advance(3);
  endtask

  initial begin
    rst_n_i = 1'b0;
    cen_i   = 1'b0;
    psc_preload_i = '0;
    arr_preload_i = '0;
    set_ch_a('0, '0, '0, '0);
    set_ch_b('0, '0, '0, '0);
    advance(2);
    push('0, FULL, 0);
    push('0, FULL, 0);
    advance(2);
    rst_n_i = 1'b1;
    push('0, FULL, 0);
    advance(1);

    // 1: 3-of-10 pulse, uev every 10; cen drops exactly when cnt==arr (no uev)
    psc_preload_i = 16'd0;
    arr_preload_i = 16'd9;
    set_ch_a(16'd2, 16'd5, 16'h1, 8'd0);
    set_ch_b(16'd0, 16'd0, 16'h0, 8'd0);
    cen_i = 1'b1;
    for (int k = -1; k <= 28; k++)
      push(vec((k >= 0) && (k % 10 >= 4) && (k % 10 <= 6), 1'b0, 1'b0, 1'b0,
               uev10(k), cnt10(k)), FULL, 1);
    advance(30);
    stop_timer(1'b0, 1'b0, 1'b0, 1'b0, 1);

    // 2: complementary pair with 2-cycle dead time
    set_ch_a(16'd2, 16'd5, 16'h5, 8'd2);
    cen_i = 1'b1;
    for (int k = -1; k <= 29; k++)
      push(vec(t2_main(k - 1), t2_comp(k - 1), 1'b0, 1'b0, uev10(k), cnt10(k)), FULL, 2);
    advance(31);
    stop_timer(1'b0, 1'b0, 1'b0, 1'b0, 2);

    // 3: prescaler /4, period 5 ticks; arr write mid-period lands at the next uev
    psc_preload_i = 16'd3;
    arr_preload_i = 16'd4;
    set_ch_a(16'd0, 16'd0, 16'h0, 8'd0);
    cen_i = 1'b1;
    for (int k = -1; k <= 25; k++)
      push(vec(1'b0, 1'b0, 1'b0, 1'b0, (k > 0) && (k % 20 == 0),
               (k < 0) ? '0 : WIDTH'((k / 4) % 5)), FULL, 3);
    advance(27);
    arr_preload_i = 16'd1;
    for (int k = 26; k <= 63; k++) begin
      if (k < 40)
        push(vec(1'b0, 1'b0, 1'b0, 1'b0, (k % 20 == 0), WIDTH'((k / 4) % 5)), FULL, 3);
      else
        push(vec(1'b0, 1'b0, 1'b0, 1'b0, ((k - 40) % 8 == 0), WIDTH'(((k - 40) / 4) % 2)),
             FULL, 3);
    end
    advance(38);
    stop_timer(1'b0, 1'b0, 1'b0, 1'b0, 3);

    // 4: wrap-around window 8..1 on A; start==end on B with POL stays at idle level 1
    psc_preload_i = 16'd0;
    arr_preload_i = 16'd9;
    set_ch_a(16'd8, 16'd2, 16'h1, 8'd0);
    set_ch_b(16'd4, 16'd4, 16'h3, 8'd0);
    cen_i = 1'b1;
    for (int k = -1; k <= 29; k++)
      push(vec((k >= 2) && (((k - 2) % 10 >= 8) || ((k - 2) % 10 <= 1)), 1'b0, (k >= 1),
               1'b0, uev10(k), cnt10(k)), FULL, 4);
    advance(31);
    stop_timer(1'b0, 1'b0, 1'b1, 1'b0, 4);

    // 5: dead time longer than the pulse; B disabled with POL=1
    set_ch_a(16'd2, 16'd5, 16'h5, 8'd5);
    set_ch_b(16'd0, 16'd0, 16'h2, 8'd0);
    cen_i = 1'b1;
    for (int k = -1; k <= 29; k++)
      push(vec(1'b0, t5_comp(k - 1), 1'b1, 1'b0, uev10(k), cnt10(k)), FULL, 5);
    advance(31);
    stop_timer(1'b0, 1'b0, 1'b1, 1'b0, 5);

    // 6: asynchronous reset mid-period, then restart from a forced load
    set_ch_a(16'd2, 16'd5, 16'h1, 8'd0);
    cen_i = 1'b1;
    for (int k = -1; k <= 14; k++)
      push(vec((k >= 0) && (k % 10 >= 4) && (k % 10 <= 6), 1'b0, 1'b1, 1'b0,
               uev10(k), cnt10(k)), FULL, 6);
    advance(16);
    rst_n_i = 1'b0;
    push('0, FULL, 6);
    push('0, FULL, 6);
    advance(2);
    rst_n_i = 1'b1;
    for (int k = -1; k <= 12; k++)
      push(vec((k >= 0) && (k % 10 >= 4) && (k % 10 <= 6), 1'b0, (k >= 1), 1'b0,
               uev10(k), cnt10(k)), FULL, 6);
    advance(14);

    // report
    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d expected vectors left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
